// File: rtl/omem_drain_unit_pkg.sv
// ---------------------------------------------------------------------------
// omem_drain_unit_pkg
// Shared constants and types for the OMEM drain unit.
//
// Build option:
//   OMEM_DRAIN_FULL_ADDR_EN - when defined, each FIFO entry keeps the full
//   96-bit OMEM address and streams as 6 beats (ADDR_X, ADDR_Y, ADDR_Z,
//   X, Y, Z). When undefined, only Address[31:0] is kept and each entry
//   streams as 4 beats (ADDR, X, Y, Z).
// ---------------------------------------------------------------------------
package omem_drain_unit_pkg;

    localparam int OMEM_WORD_WIDTH = 32;
    localparam int OMEM_ROW_WIDTH  = 3 * OMEM_WORD_WIDTH;

`ifdef OMEM_DRAIN_FULL_ADDR_EN
    localparam int OMEM_BEATS_PER_ENTRY = 6;
    localparam int OMEM_ADDR_KEEP_WIDTH = OMEM_ROW_WIDTH;

    typedef enum logic [2:0] {
        BEAT_ADDR_X = 3'd0,
        BEAT_ADDR_Y = 3'd1,
        BEAT_ADDR_Z = 3'd2,
        BEAT_X      = 3'd3,
        BEAT_Y      = 3'd4,
        BEAT_Z      = 3'd5
    } beatIndexT;

    localparam beatIndexT BEAT_FIRST = BEAT_ADDR_X;
`else
    localparam int OMEM_BEATS_PER_ENTRY = 4;
    localparam int OMEM_ADDR_KEEP_WIDTH = OMEM_WORD_WIDTH;

    typedef enum logic [1:0] {
        BEAT_ADDR = 2'd0,
        BEAT_X    = 2'd1,
        BEAT_Y    = 2'd2,
        BEAT_Z    = 2'd3
    } beatIndexT;

    localparam beatIndexT BEAT_FIRST = BEAT_ADDR;
`endif

    localparam beatIndexT BEAT_LAST = BEAT_Z;

    // Entry layout: {kept address bits, Data[95:0]}
    localparam int OMEM_ENTRY_WIDTH = OMEM_ADDR_KEEP_WIDTH + OMEM_ROW_WIDTH;

endpackage

// File: rtl/omem_drain_unit_fifo.sv
// ---------------------------------------------------------------------------
// omem_drain_fifo
// Generic synchronous FIFO with a combinational head read.
//
// Ports:
//   Clock, Reset   - clock and synchronous active-high reset
//   push, din      - write din at the clock edge (caller guarantees room,
//                    or a pop in the same cycle when full)
//   pop            - retire the head entry (ignored while empty)
//   dout           - current head entry
//   full, empty    - occupancy flags
//   count          - number of stored entries (0..DEPTH)
//
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate counter.
// ---------------------------------------------------------------------------
module omem_drain_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 8
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wrPtr;
    logic [AW:0]      rdPtr;
    logic             doPop;

    assign doPop = pop && !empty;

    // Storage has no reset; only the pointers define which slots are live.
    always_ff @(posedge Clock) begin
        if (push) begin
            mem[wrPtr[AW-1:0]] <= din;
        end
    end

    // Pointer update; a push and a pop in the same cycle move both pointers,
    // which is what keeps the count unchanged when full.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
        end
    end

    assign dout  = mem[rdPtr[AW-1:0]];
    assign empty = (wrPtr == rdPtr);
    assign full  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign count = wrPtr - rdPtr;

endmodule

// File: rtl/omem_drain_unit.sv
// ---------------------------------------------------------------------------
// omem_drain_unit
// Captures every OMEM write from the execution unit into a FIFO and
// serialises each entry onto a 32-bit valid/ready stream. The core cannot
// be stalled, so writes arriving while the FIFO is full are dropped and
// counted in a saturating counter.
//
// Ports:
//   Clock, Reset        - clock, synchronous active-high reset
//   iOMEMWriteAddress   - OMEM address row (X,Y,Z words)
//   iOMEMWriteData      - OMEM data row (X,Y,Z words)
//   iOMEMWriteEnable    - one entry captured per high cycle
//   oStreamData         - current beat (0 while empty)
//   oStreamValid        - beat valid (FIFO not empty)
//   iStreamReady        - sink accepts the beat on Valid & Ready
//   oStreamLast         - final beat of an entry
//   oFull, oEmpty       - FIFO occupancy flags
//   oOverflowCount      - saturating count of dropped writes
//
// Build option: OMEM_DRAIN_FULL_ADDR_EN (see omem_drain_unit_pkg).
// ---------------------------------------------------------------------------
module omem_drain_unit
    import omem_drain_unit_pkg::*;
#(
    parameter int DATA_ROW_WIDTH = 96,
    parameter int WORD_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 8,
    parameter int OVF_CNT_WIDTH  = 16
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic [DATA_ROW_WIDTH-1:0] iOMEMWriteAddress,
    input  logic [DATA_ROW_WIDTH-1:0] iOMEMWriteData,
    input  logic                      iOMEMWriteEnable,
    output logic [WORD_WIDTH-1:0]     oStreamData,
    output logic                      oStreamValid,
    input  logic                      iStreamReady,
    output logic                      oStreamLast,
    output logic                      oFull,
    output logic                      oEmpty,
    output logic [OVF_CNT_WIDTH-1:0]  oOverflowCount
);

    logic [OMEM_ENTRY_WIDTH-1:0]   entryIn;
    logic [OMEM_ENTRY_WIDTH-1:0]   headEntry;
    logic                          fifoFull;
    logic                          fifoEmpty;
    logic [$clog2(FIFO_DEPTH):0]   unusedFifoCount;
    logic                          handshake;
    logic                          popEntry;
    logic                          pushEntry;
    logic                          dropEntry;
    beatIndexT                     beat;
    beatIndexT                     beatNext;
    logic [WORD_WIDTH-1:0]         beatWord;
    logic [OVF_CNT_WIDTH-1:0]      ovfCount;

`ifdef OMEM_DRAIN_FULL_ADDR_EN
    assign entryIn = {iOMEMWriteAddress, iOMEMWriteData};
`else
    logic unusedAddrHi;
    assign entryIn      = {iOMEMWriteAddress[OMEM_WORD_WIDTH-1:0], iOMEMWriteData};
    assign unusedAddrHi = ^iOMEMWriteAddress[DATA_ROW_WIDTH-1:OMEM_WORD_WIDTH];
`endif

    // The entry pops on the handshake of its last beat; a write in that same
    // cycle takes the freed slot, so a full FIFO only drops when not popping.
    assign handshake = !fifoEmpty && iStreamReady;
    assign popEntry  = handshake && (beat == BEAT_LAST);
    assign pushEntry = iOMEMWriteEnable && (!fifoFull || popEntry);
    assign dropEntry = iOMEMWriteEnable && fifoFull && !popEntry;

    omem_drain_fifo #(
        .WIDTH (OMEM_ENTRY_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) uFifo (
        .Clock (Clock),
        .Reset (Reset),
        .push  (pushEntry),
        .pop   (popEntry),
        .din   (entryIn),
        .dout  (headEntry),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .count (unusedFifoCount)
    );

    // Beat counter register; reset discards any partially sent entry.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            beat <= BEAT_FIRST;
        end else begin
            beat <= beatNext;
        end
    end

    // Beat counter only moves on a handshake, wrapping after the Z word.
    always_comb begin
        beatNext = beat;
        if (handshake) begin
            if (beat == BEAT_LAST) begin
                beatNext = BEAT_FIRST;
            end else begin
                beatNext = beatIndexT'(beat + 1'b1);
            end
        end
    end

    // Select the head-entry word for the current beat; zero while empty.
    always_comb begin
        beatWord = '0;
        if (!fifoEmpty) begin
            case (beat)
`ifdef OMEM_DRAIN_FULL_ADDR_EN
                BEAT_ADDR_X: beatWord = headEntry[191:160];
                BEAT_ADDR_Y: beatWord = headEntry[159:128];
                BEAT_ADDR_Z: beatWord = headEntry[127:96];
`else
                BEAT_ADDR:   beatWord = headEntry[127:96];
`endif
                BEAT_X:      beatWord = headEntry[95:64];
                BEAT_Y:      beatWord = headEntry[63:32];
                BEAT_Z:      beatWord = headEntry[31:0];
                default:     beatWord = '0;
            endcase
        end
    end

    // Dropped-write counter sticks at all-ones instead of wrapping.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            ovfCount <= '0;
        end else if (dropEntry && (ovfCount != '1)) begin
            ovfCount <= ovfCount + 1'b1;
        end
    end

    assign oStreamData    = beatWord;
    assign oStreamValid   = !fifoEmpty;
    assign oStreamLast    = !fifoEmpty && (beat == BEAT_LAST);
    assign oFull          = fifoFull;
    assign oEmpty         = fifoEmpty;
    assign oOverflowCount = ovfCount;

endmodule

// File: tb/tb_omem_drain_unit.sv
// ---------------------------------------------------------------------------
// tb_omem_drain_unit
// Directed self-checking bench for omem_drain_unit (default 4-beat build).
// A second instance with a 4-bit overflow counter covers saturation.
// ---------------------------------------------------------------------------
module tb_omem_drain_unit;

    logic        Clock;
    logic        Reset;
    logic [95:0] wrAddr;
    logic [95:0] wrData;
    logic        wrEn;
    logic        ready;
    logic [31:0] sData;
    logic        sValid;
    logic        sLast;
    logic        full;
    logic        empty;
    logic [15:0] ovf;

    logic        wrEn4;
    logic        ready4;
    logic [31:0] sData4;
    logic        sValid4;
    logic        sLast4;
    logic        full4;
    logic        empty4;
    logic [3:0]  ovf4;

    int errors = 0;
    int checks = 0;
    logic [31:0] expQ[$];

    omem_drain_unit dut (
        .Clock             (Clock),
        .Reset             (Reset),
        .iOMEMWriteAddress (wrAddr),
        .iOMEMWriteData    (wrData),
        .iOMEMWriteEnable  (wrEn),
        .oStreamData       (sData),
        .oStreamValid      (sValid),
        .iStreamReady      (ready),
        .oStreamLast       (sLast),
        .oFull             (full),
        .oEmpty            (empty),
        .oOverflowCount    (ovf)
    );

    omem_drain_unit #(.OVF_CNT_WIDTH(4)) dut4 (
        .Clock             (Clock),
        .Reset             (Reset),
        .iOMEMWriteAddress (wrAddr),
        .iOMEMWriteData    (wrData),
        .iOMEMWriteEnable  (wrEn4),
        .oStreamData       (sData4),
        .oStreamValid      (sValid4),
        .iStreamReady      (ready4),
        .oStreamLast       (sLast4),
        .oFull             (full4),
        .oEmpty            (empty4),
        .oOverflowCount    (ovf4)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic doReset();
        wrEn   = 1'b0;
        wrEn4  = 1'b0;
        ready  = 1'b0;
        Reset  = 1'b1;
        step();
        step();
        Reset  = 1'b0;
        expQ.delete();
    endtask

    task automatic applyStimulus(input int i);
        wrAddr = {64'hDEAD_BEEF_CAFE_F00D, 32'(32'h100 + i)};
        wrData = {32'(32'h1000_0000 + i), 32'(32'h2000_0000 + i), 32'(32'h3000_0000 + i)};
        wrEn   = 1'b1;
        step();
        wrEn   = 1'b0;
    endtask

    task automatic expectEntry(input int i);
        expQ.push_back(32'(32'h100 + i));
        expQ.push_back(32'(32'h1000_0000 + i));
        expQ.push_back(32'(32'h2000_0000 + i));
        expQ.push_back(32'(32'h3000_0000 + i));
    endtask

    // Drain the expected queue with Ready held high, checking {Last, Data}.
    task automatic drainAll(input string tag);
        int idx = 0;
        int cyc = 0;
        ready = 1'b1;
        while (expQ.size() > 0 && cyc < 200) begin
            checkOutput({tag, "Valid"}, 64'(sValid), 64'd1);
            if (sValid) begin
                checkOutput({tag, "Beat"}, {31'd0, sLast, sData}, {31'd0, (idx % 4) == 3, expQ[0]});
                void'(expQ.pop_front());
                idx++;
            end
            step();
            cyc++;
        end
        if (expQ.size() > 0) checkOutput({tag, "Timeout"}, 64'd0, 64'd1);
        ready = 1'b0;
        checkOutput({tag, "EmptyAfter"}, 64'(empty), 64'd1);
    endtask

    initial begin
        wrAddr = '0;
        wrData = '0;
        ready4 = 1'b0;
        doReset();

        // Reset state
        checkOutput("rstValid", 64'(sValid), 64'd0);
        checkOutput("rstLast",  64'(sLast),  64'd0);
        checkOutput("rstEmpty", 64'(empty),  64'd1);
        checkOutput("rstFull",  64'(full),   64'd0);
        checkOutput("rstOvf",   64'(ovf),    64'd0);
        checkOutput("rstData",  64'(sData),  64'd0);

        // Test 1: single write, full-speed sink
        ready  = 1'b1;
        wrAddr = {64'h1111_2222_3333_4444, 32'h0000_0010};
        wrData = {32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
        wrEn   = 1'b1;
        checkOutput("t1NoBypass", 64'(sValid), 64'd0);
        step();
        wrEn = 1'b0;
        expQ.push_back(32'h0000_0010);
        expQ.push_back(32'h3F80_0000);
        expQ.push_back(32'h4000_0000);
        expQ.push_back(32'h4040_0000);
        drainAll("t1");

        // Test 2: backpressure, Ready toggling every cycle
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(i);
            expectEntry(i);
        end
        begin
            int idx = 0;
            int cyc = 0;
            while (expQ.size() > 0 && cyc < 100) begin
                ready = (cyc % 2 == 0);
                checkOutput("t2Beat", {31'd0, sValid, sLast, sData}, {31'd0, 1'b1, (idx % 4) == 3, expQ[0]});
                if (ready) begin
                    void'(expQ.pop_front());
                    idx++;
                end
                step();
                cyc++;
            end
            if (expQ.size() > 0) checkOutput("t2Timeout", 64'd0, 64'd1);
            ready = 1'b0;
            checkOutput("t2Empty", 64'(empty), 64'd1);
            checkOutput("t2Ovf", 64'(ovf), 64'd0);
        end

        // Test 3: overflow with Ready low
        doReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(i);
            if (i < 8) expectEntry(i);
            if (i == 6) checkOutput("t3NotFull7", 64'(full), 64'd0);
            if (i == 7) checkOutput("t3Full8", 64'(full), 64'd1);
        end
        checkOutput("t3Ovf", 64'(ovf), 64'd2);
        checkOutput("t3HeadHeld", {31'd0, sLast, sData}, {31'd0, 1'b0, 32'h100});
        drainAll("t3");

        // Test 4: full FIFO, pop on BEAT_Z and write in the same cycle
        doReset();
        for (int i = 0; i < 8; i++) applyStimulus(i);
        checkOutput("t4Full", 64'(full), 64'd1);
        ready = 1'b1;
        checkOutput("t4Addr", 64'(sData), 64'h100);
        step();
        checkOutput("t4X", 64'(sData), 64'h1000_0000);
        step();
        checkOutput("t4Y", 64'(sData), 64'h2000_0000);
        step();
        checkOutput("t4Z", {31'd0, sLast, sData}, {31'd0, 1'b1, 32'h3000_0000});
        applyStimulus(8);
        checkOutput("t4StillFull", 64'(full), 64'd1);
        checkOutput("t4NoDrop", 64'(ovf), 64'd0);
        for (int i = 1; i < 9; i++) expectEntry(i);
        drainAll("t4");

        // Test 5: reset after the BEAT_X handshake
        doReset();
        for (int i = 0; i < 9; i++) applyStimulus(i);
        checkOutput("t5OvfBefore", 64'(ovf), 64'd1);
        ready = 1'b1;
        step();
        step();
        checkOutput("t5AtY", 64'(sData), 64'h2000_0000);
        ready = 1'b0;
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        checkOutput("t5Valid", 64'(sValid), 64'd0);
        checkOutput("t5Empty", 64'(empty),  64'd1);
        checkOutput("t5Ovf",   64'(ovf),    64'd0);
        applyStimulus(20);
        expectEntry(20);
        drainAll("t5");

        // Test 6: saturation of a 4-bit overflow counter
        doReset();
        wrAddr = '0;
        wrData = '0;
        wrEn4  = 1'b1;
        for (int c = 1; c <= 28; c++) begin
            step();
            if (c == 22) checkOutput("t6Ovf14", 64'(ovf4), 64'hE);
            if (c == 23) checkOutput("t6Ovf15", 64'(ovf4), 64'hF);
        end
        wrEn4 = 1'b0;
        checkOutput("t6OvfSat", 64'(ovf4), 64'hF);
        checkOutput("t6Full", 64'(full4), 64'd1);
        checkOutput("t6OtherOvf", 64'(ovf), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/omem_drain_unit.md
Name: omem_drain_unit

Overview:
Receiver for the execution unit's output-memory write port (OMEM write address, data and enable). It captures every OMEM write into a small synchronous FIFO and serialises each entry onto a 32-bit valid/ready stream toward the host or bus bridge. The core has no stall input, so writes that arrive while the FIFO is full are dropped and counted. Sits between the execution unit and the host interface, one instance per core.

Parameters:
DATA_ROW_WIDTH, 96, width of the OMEM address and data rows (three 32-bit components X, Y, Z).
WORD_WIDTH, 32, stream beat width.
FIFO_DEPTH, 8, number of buffered OMEM writes; power of two, minimum 2.
OVF_CNT_WIDTH, 16, width of the dropped-write counter.

Ports:
Clock  in  1  single clock domain.
Reset  in  1  synchronous, active-high.
iOMEMWriteAddress  in  DATA_ROW_WIDTH  OMEM address row from the core.
iOMEMWriteData  in  DATA_ROW_WIDTH  OMEM data row from the core.
iOMEMWriteEnable  in  1  one-cycle write strobe; one entry per high cycle.
oStreamData  out  WORD_WIDTH  current beat.
oStreamValid  out  1  beat valid.
iStreamReady  in  1  sink accepts the beat when Valid and Ready are both high.
oStreamLast  out  1  high on the final beat of an entry.
oFull  out  1  FIFO holds FIFO_DEPTH entries.
oEmpty  out  1  FIFO holds 0 entries.
oOverflowCount  out  OVF_CNT_WIDTH  writes dropped while full; saturates.

Behaviour:
- One clock (Clock); reset is synchronous and active-high (Reset).
- Reset values:
  - FIFO pointers and count = 0; beat counter = 0.
  - oStreamValid = 0, oStreamLast = 0, oEmpty = 1, oFull = 0, oOverflowCount = 0.
  - oStreamData = 0 while empty.
- A Reset asserted mid-entry discards all buffered entries and any partially sent entry. No beats appear on the cycle after Reset.
- FIFO entry format: {Address[31:0], Data[95:0]}, 128 bits. Only the low address word is kept unless the optional feature is enabled.
- Push: iOMEMWriteEnable high and (not full, or a pop happens in the same cycle) -> entry written at the clock edge.
- Drop: iOMEMWriteEnable high, full and no pop -> entry dropped; oOverflowCount increments. The counter holds at all-ones.
- Latency: an entry pushed at edge N makes oStreamValid high in cycle N+1 (registered FIFO, combinational head read). No bypass from input to stream.
- Beat sequencing: a 2-bit beat counter (BEAT_ADDR, BEAT_X, BEAT_Y, BEAT_Z) runs over the FIFO head entry.
  - BEAT_ADDR = Address[31:0].
  - BEAT_X = Data[95:64].
  - BEAT_Y = Data[63:32].
  - BEAT_Z = Data[31:0].
- Beat counter advance:
  - The counter advances only on a Valid & Ready handshake.
  - On the BEAT_Z handshake, the FIFO pops and the counter returns to BEAT_ADDR.
  - oStreamLast = Valid & (beat == BEAT_Z).
- oStreamValid = not empty. Once Valid is high, oStreamData and oStreamLast stay stable until the handshake (AXI-stream style). Valid never drops mid-entry.
- Simultaneous push and pop:
  - When full: both happen and the count is unchanged; no drop.
  - When the count is 1: the new entry becomes head at the next cycle and Valid stays high.
- Pointer wrap-around: pointers are log2(FIFO_DEPTH) bits plus one extra wrap bit. full = (MSBs differ, rest equal); empty = (pointers equal).
- iStreamReady held low indefinitely: the FIFO fills, then further writes are dropped and counted. The beat counter and head entry are untouched.

Optional Feature:
- Macro: OMEM_DRAIN_FULL_ADDR_EN.
- Defined:
  - Entry stores the full 96-bit address (192-bit entry).
  - Each entry streams 6 beats: ADDR_X Address[95:64], ADDR_Y Address[63:32], ADDR_Z Address[31:0], then X, Y, Z.
  - Beat counter is 3 bits; oStreamLast on beat 5.
- Undefined: 4-beat format as above.

Decomposition:
- Shared package / `define header constants:
  - OMEM_WORD_WIDTH = 32.
  - OMEM_BEATS_PER_ENTRY = 4, or 6 under the macro.
  - OMEM_ENTRY_WIDTH.
  - Beat index encodings: BEAT_ADDR = 0, BEAT_X = 1, BEAT_Y = 2, BEAT_Z = 3.
- One sub-module: omem_drain_fifo.
  - Generic synchronous FIFO with parameterised width and depth.
  - Ports: push, pop, din, dout (head), full, empty, count.
  - Simultaneous push/pop when full is legal.
- Top level holds the beat counter, output mux, drop logic and overflow counter.

Test Plan:
1. Single write: Address=0x0000_0010, Data={0x3F800000, 0x40000000, 0x40400000}, Ready=1 -> Valid from the next cycle. Beats 0x10, 0x3F800000, 0x40000000, 0x40400000 on consecutive cycles; Last on the 4th; oEmpty=1 afterwards.
2. Backpressure: 3 writes, Ready toggling 1/0 every cycle -> 12 beats in order, data stable while Ready=0, Last every 4th beat, no drops.
3. Overflow: Ready=0, 10 consecutive writes with FIFO_DEPTH=8 -> oFull=1 after 8 writes, oOverflowCount=2. Releasing Ready drains exactly the first 8 entries.
4. Full with simultaneous pop: FIFO full, head on BEAT_Z with Ready=1, and a write in the same cycle -> no drop, count stays 8. The new entry is streamed last.
5. Reset mid-entry: Reset asserted after the BEAT_X handshake -> next cycle Valid=0, oEmpty=1, oOverflowCount=0. A subsequent write starts at BEAT_ADDR.
6. Saturation with OVF_CNT_WIDTH=4: 20 writes into a full FIFO with Ready=0 -> oOverflowCount holds at 0xF.
